// File: rtl/rom_game_loader_if.sv
// Flash-reader request/response and SDRAM write-port signals of the game loader.
interface rom_game_loader_if;
    logic        loading;
    logic        flashmem_ready;
    logic [23:0] flash_address;
    logic [15:0] flash_dout;
    logic        wren;
    logic [24:0] load_address;
    logic [15:0] load_data;

    modport master (
        output loading, flash_address, wren, load_address, load_data,
        input  flashmem_ready, flash_dout
    );

    modport slave (
        input  loading, flash_address, wren, load_address, load_data,
        output flashmem_ready, flash_dout
    );
endinterface

// File: rtl/rom_game_loader.sv
// Copies one game image (4-word header + ROM) from SPI flash into SDRAM before core release.
// Optional macro LOADER_BSRAM_CLEAR_EN adds a BSRAM zero-fill phase after the ROM copy.
module rom_game_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h200000,
    parameter int unsigned SLOT_SHIFT = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                sel,
    output logic                      ready,
    rom_game_loader_if.master         mem,
    output logic [7:0]                rom_type,
    output logic [23:0]               rom_mask,
    output logic [23:0]               ram_mask
);

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_ROM   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef LOADER_BSRAM_CLEAR_EN
    localparam logic [2:0] ST_CLR   = 3'd4;
    localparam logic [24:0] BSRAM_BASE = 25'h1000000;
`endif

    logic [2:0]    state_q, state_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic [AW-1:0] rom_off_q, rom_off_d;
`ifdef LOADER_BSRAM_CLEAR_EN
    logic [AW-1:0] clr_off_q, clr_off_d;
`endif
    logic          ready_q, ready_d;
    logic          loading_q, loading_d;
    logic [AW-1:0] flash_address_q, flash_address_d;
    logic          wren_q, wren_d;
    logic [AW:0]   load_address_q, load_address_d;
    logic [DW-1:0] load_data_q, load_data_d;
    logic [7:0]    rom_type_q, rom_type_d;
    logic [AW-1:0] rom_mask_q, rom_mask_d;
    logic [AW-1:0] ram_mask_q, ram_mask_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_START;
            hdr_idx_q       <= 2'd0;
            rom_off_q       <= '0;
`ifdef LOADER_BSRAM_CLEAR_EN
            clr_off_q       <= '0;
`endif
            ready_q         <= 1'b0;
            loading_q       <= 1'b0;
            flash_address_q <= '0;
            wren_q          <= 1'b0;
            load_address_q  <= '0;
            load_data_q     <= '0;
            rom_type_q      <= '0;
            rom_mask_q      <= '0;
            ram_mask_q      <= '0;
        end else begin
            state_q         <= state_d;
            hdr_idx_q       <= hdr_idx_d;
            rom_off_q       <= rom_off_d;
`ifdef LOADER_BSRAM_CLEAR_EN
            clr_off_q       <= clr_off_d;
`endif
            ready_q         <= ready_d;
            loading_q       <= loading_d;
            flash_address_q <= flash_address_d;
            wren_q          <= wren_d;
            load_address_q  <= load_address_d;
            load_data_q     <= load_data_d;
            rom_type_q      <= rom_type_d;
            rom_mask_q      <= rom_mask_d;
            ram_mask_q      <= ram_mask_d;
        end
    end

    // A request is captured only while loading is high; the following cycle
    // (loading low) launches the next request at the next word address.
    always_comb begin
        state_d         = state_q;
        hdr_idx_d       = hdr_idx_q;
        rom_off_d       = rom_off_q;
`ifdef LOADER_BSRAM_CLEAR_EN
        clr_off_d       = clr_off_q;
`endif
        ready_d         = ready_q;
        loading_d       = loading_q;
        flash_address_d = flash_address_q;
        wren_d          = 1'b0;
        load_address_d  = load_address_q;
        load_data_d     = load_data_q;
        rom_type_d      = rom_type_q;
        rom_mask_d      = rom_mask_q;
        ram_mask_d      = ram_mask_q;

        case (state_q)
            ST_START: begin
                flash_address_d = FLASH_BASE + (AW'(sel) << SLOT_SHIFT);
                loading_d       = 1'b1;
                hdr_idx_d       = 2'd0;
                state_d         = ST_HDR;
            end

            ST_HDR: begin
                if (!loading_q) begin
                    loading_d       = 1'b1;
                    flash_address_d = flash_address_q + AW'(2);
                end else if (mem.flashmem_ready) begin
                    loading_d = 1'b0;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0: begin
                            if (mem.flash_dout == 16'hFFFF) begin
                                rom_type_d = '0;
                                rom_mask_d = '0;
                                ram_mask_d = '0;
                                state_d    = ST_DONE;
                            end else begin
                                rom_type_d = mem.flash_dout[7:0];
                            end
                        end
                        2'd1: begin
                            rom_mask_d[23:16] = mem.flash_dout[7:0];
                            ram_mask_d[23:16] = mem.flash_dout[15:8];
                        end
                        2'd2: rom_mask_d[15:0] = mem.flash_dout;
                        default: begin
                            ram_mask_d[15:0] = mem.flash_dout;
                            rom_off_d        = '0;
                            state_d          = ST_ROM;
                        end
                    endcase
                end
            end

            ST_ROM: begin
                if (!loading_q) begin
                    loading_d       = 1'b1;
                    flash_address_d = flash_address_q + AW'(2);
                end else if (mem.flashmem_ready) begin
                    loading_d      = 1'b0;
                    wren_d         = 1'b1;
                    load_data_d    = mem.flash_dout;
                    load_address_d = {1'b0, rom_off_q};
                    if (rom_off_q == (rom_mask_q & ~AW'(1))) begin
`ifdef LOADER_BSRAM_CLEAR_EN
                        clr_off_d = '0;
                        state_d   = ST_CLR;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        rom_off_d = rom_off_q + AW'(2);
                    end
                end
            end

`ifdef LOADER_BSRAM_CLEAR_EN
            // Zero-fill BSRAM, one write every other cycle.
            ST_CLR: begin
                if (!wren_q) begin
                    wren_d         = 1'b1;
                    load_data_d    = '0;
                    load_address_d = BSRAM_BASE | {1'b0, clr_off_q};
                    if (clr_off_q == (ram_mask_q & ~AW'(1))) begin
                        state_d = ST_DONE;
                    end else begin
                        clr_off_d = clr_off_q + AW'(2);
                    end
                end
            end
`endif

            ST_DONE: begin
                ready_d   = 1'b1;
                loading_d = 1'b0;
            end

            default: state_d = ST_START;
        endcase
    end

    assign ready             = ready_q;
    assign mem.loading       = loading_q;
    assign mem.flash_address = flash_address_q;
    assign mem.wren          = wren_q;
    assign mem.load_address  = load_address_q;
    assign mem.load_data     = load_data_q;
    assign rom_type          = rom_type_q;
    assign rom_mask          = rom_mask_q;
    assign ram_mask          = ram_mask_q;

endmodule

// File: tb/tb_rom_game_loader.sv
// Directed bench for rom_game_loader: flash reader model, write logger, immediate-assertion checks.
module tb_rom_game_loader;

`ifdef LOADER_BSRAM_CLEAR_EN
    localparam int CLR_7FF = 1024;
    localparam int CLR_007 = 4;
`else
    localparam int CLR_7FF = 0;
    localparam int CLR_007 = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic        ready;
    logic [7:0]  rom_type;
    logic [23:0] rom_mask;
    logic [23:0] ram_mask;

    rom_game_loader_if bus ();

    rom_game_loader dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .ready    (ready),
        .mem      (bus),
        .rom_type (rom_type),
        .rom_mask (rom_mask),
        .ram_mask (ram_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // flash image model
    logic [15:0] hdr   [4];
    logic [15:0] rom_w [4];
    logic [23:0] cur_base;
    int          lat;
    logic        spur_en;

    int          nreads;
    logic [23:0] read_addr [16];
    int          viol;
    int          nwr;
    int          overlap;
    logic [24:0] wr_addr [2048];
    logic [15:0] wr_data [2048];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flash_word(input logic [23:0] a);
        int idx;
        idx = int'((a - cur_base) >> 1);
        if (idx >= 0 && idx < 4) return hdr[idx];
        if (idx >= 4 && idx < 8) return rom_w[idx-4];
        return 16'hDEAD;
    endfunction

    // Flash reader: answers each request after lat+1 cycles and tracks handshake stability.
    initial begin : flash_model
        logic        prev_load;
        logic [23:0] prev_addr;
        logic        prev_fmr;
        int          wait_cnt;
        prev_load = 1'b0; prev_addr = '0; prev_fmr = 1'b0; wait_cnt = 0;
        bus.flashmem_ready = 1'b0;
        bus.flash_dout     = 16'h0000;
        forever begin
            @(negedge clk);
            if (prev_load && bus.loading && bus.flash_address != prev_addr) viol++;
            if (prev_load && !bus.loading && !prev_fmr) viol++;
            prev_load = bus.loading;
            prev_addr = bus.flash_address;
            bus.flashmem_ready = 1'b0;
            if (bus.loading) begin
                if (wait_cnt >= lat) begin
                    bus.flashmem_ready = 1'b1;
                    bus.flash_dout     = flash_word(bus.flash_address);
                    if (nreads < 16) read_addr[nreads] = bus.flash_address;
                    nreads++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (spur_en) begin
                    bus.flashmem_ready = 1'b1;
                    bus.flash_dout     = 16'hBEEF;
                end
            end
            prev_fmr = bus.flashmem_ready;
        end
    end

    initial begin : wr_logger
        logic prev_wren;
        prev_wren = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wren) begin
                if (nwr < 2048) begin
                    wr_addr[nwr] = bus.load_address;
                    wr_data[nwr] = bus.load_data;
                end
                nwr++;
                if (prev_wren) overlap++;
            end
            prev_wren = bus.wren;
        end
    end

    task automatic clear_logs();
        nreads = 0; nwr = 0; viol = 0; overlap = 0;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
    endtask

    task automatic small_image(input logic [15:0] h3);
        hdr[0] = 16'h0001; hdr[1] = 16'h0000; hdr[2] = 16'h0007; hdr[3] = h3;
        rom_w[0] = 16'hA0A1; rom_w[1] = 16'hA1A2; rom_w[2] = 16'hA2A3; rom_w[3] = 16'hA3A4;
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    task automatic check_rom_writes(input string tag);
        check({tag, "_a0"}, 32'(wr_addr[0]), 32'h0);
        check({tag, "_d0"}, 32'(wr_data[0]), 32'hA0A1);
        check({tag, "_a3"}, 32'(wr_addr[3]), 32'h6);
        check({tag, "_d3"}, 32'(wr_data[3]), 32'hA3A4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   32'(ready), 32'd0);
        check({tag, "_loading"}, 32'(bus.loading), 32'd0);
        check({tag, "_wren"},    32'(bus.wren), 32'd0);
        check({tag, "_faddr"},   32'(bus.flash_address), 32'd0);
        check({tag, "_laddr"},   32'(bus.load_address), 32'd0);
        check({tag, "_ldata"},   32'(bus.load_data), 32'd0);
        check({tag, "_type"},    32'(rom_type), 32'd0);
        check({tag, "_rmask"},   32'(rom_mask), 32'd0);
        check({tag, "_bmask"},   32'(ram_mask), 32'd0);
    endtask

    initial begin : stimulus
        int n;
        reset = 1'b1; sel = 3'd0; lat = 2; spur_en = 1'b0; cur_base = 24'h200000;
        clear_logs();

        // reset state
        small_image(16'h07FF);
        hold_reset();
        check_all_zero("rst");

        // blank flash
        hdr[0] = 16'hFFFF;
        reset = 1'b0;
        wait_ready("blank_ready", 200);
        repeat (3) @(negedge clk);
        check("blank_reads", 32'(nreads), 32'd1);
        check("blank_type", 32'(rom_type), 32'd0);
        check("blank_rmask", 32'(rom_mask), 32'd0);
        check("blank_bmask", 32'(ram_mask), 32'd0);
        check("blank_wren", 32'(nwr), 32'd0);

        // small image in slot 0
        hold_reset();
        small_image(16'h07FF);
        reset = 1'b0;
        wait_ready("small_ready", 6000);
        check("small_type", 32'(rom_type), 32'd1);
        check("small_rmask", 32'(rom_mask), 32'h7);
        check("small_bmask", 32'(ram_mask), 32'h7FF);
        check("small_nwr", 32'(nwr), 32'(4 + CLR_7FF));
        check("small_reads", 32'(nreads), 32'd8);
        check("small_ra0", 32'(read_addr[0]), 32'h200000);
        check("small_ra4", 32'(read_addr[4]), 32'h200008);
        check("small_ra7", 32'(read_addr[7]), 32'h20000E);
        check("small_overlap", 32'(overlap), 32'd0);
        check_rom_writes("small");

        // slot 3, sel changed after START
        hold_reset();
        small_image(16'h0007);
        sel = 3'd3; cur_base = 24'h500000;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        sel = 3'd0;
        wait_ready("slot_ready", 2000);
        check("slot_ra0", 32'(read_addr[0]), 32'h500000);
        check("slot_ra7", 32'(read_addr[7]), 32'h50000E);
        check("slot_nwr", 32'(nwr), 32'(4 + CLR_007));
        check_rom_writes("slot");
`ifdef LOADER_BSRAM_CLEAR_EN
        check("clr_a0", 32'(wr_addr[4]), 32'h1000000);
        check("clr_a1", 32'(wr_addr[5]), 32'h1000002);
        check("clr_a3", 32'(wr_addr[7]), 32'h1000006);
        check("clr_d1", 32'(wr_data[5]), 32'h0);
        check("clr_d3", 32'(wr_data[7]), 32'h0);
`endif

        // handshake stall with spurious ready pulses
        hold_reset();
        small_image(16'h0007);
        sel = 3'd0; cur_base = 24'h200000; lat = 50; spur_en = 1'b1;
        reset = 1'b0;
        wait_ready("stall_ready", 4000);
        check("stall_viol", 32'(viol), 32'd0);
        check("stall_nwr", 32'(nwr), 32'(4 + CLR_007));
        check_rom_writes("stall");
        repeat (6) @(negedge clk);
        check("stall_spur_done", 32'(nwr), 32'(4 + CLR_007));
        spur_en = 1'b0; lat = 2;

        // reset after the second ROM write
        hold_reset();
        small_image(16'h07FF);
        reset = 1'b0;
        n = 0;
        while (nwr < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", 32'(nwr >= 2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid");
        clear_logs();
        @(negedge clk);
        reset = 1'b0;
        wait_ready("mid_ready", 6000);
        check("mid_ra0", 32'(read_addr[0]), 32'h200000);
        check("mid_reads", 32'(nreads), 32'd8);
        check("mid_nwr", 32'(nwr), 32'(4 + CLR_7FF));
        check_rom_writes("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
